// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo put/get schedulers: width helpers, default widths and the
// arbiter state encoding.
package fifo_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Width of an index into a set of n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEFAULT_NUM_REQUESTERS = 4;
  localparam int unsigned DEFAULT_MAX_BURST      = 4;
  localparam int unsigned OWNER_W = idx_width(DEFAULT_NUM_REQUESTERS);
  localparam int unsigned COUNT_W = idx_width(DEFAULT_MAX_BURST);

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin pick: first asserted request scanning upward from (ptr_i + 1) mod N with wrap.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = idx_width(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);

  int unsigned  cand;
  logic [W-1:0] cand_idx;

  // Scan from the farthest candidate down so the nearest one after ptr_i wins.
  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = N; i >= 1; i--) begin
      cand     = (int'(ptr_i) + i) % N;
      cand_idx = W'(cand);
      if (req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one fifo put port among NUM_REQUESTERS producers.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MAX_BURST      = 4,
  localparam int unsigned OwnerW = idx_width(NUM_REQUESTERS),
  localparam int unsigned CountW = idx_width(MAX_BURST)
) (
  input  logic                                 in_clock,
  input  logic                                 in_reset,
  input  logic [NUM_REQUESTERS-1:0]            in_request,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQUESTERS-1:0]            out_grant,
  output logic [OwnerW-1:0]                    out_owner,
  output logic                                 out_busy,
  input  logic                                 in_full,
  output logic                                 out_put,
  output logic [DATA_WIDTH-1:0]                out_data
);

  arb_state_e          state_q, state_d;
  logic [OwnerW-1:0]   owner_q, owner_d;
  logic [OwnerW-1:0]   ptr_q, ptr_d;
  logic [CountW-1:0]   count_q, count_d;

  logic                busy, owner_req, xfer, last_item, release_own;
  logic [OwnerW-1:0]   pick_ptr, pick_idx;
  logic                pick_valid;
  logic [DATA_WIDTH-1:0] lanes [NUM_REQUESTERS];

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_lane
    assign lanes[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign busy        = (state_q == StBusy);
  assign owner_req   = in_request[owner_q];
  // The reset cycle never puts: the in-flight item is re-presented afterwards.
  assign xfer        = busy & owner_req & ~in_full & ~in_reset;
  assign last_item   = (count_q == CountW'(MAX_BURST - 1));
  assign release_own = busy & (~owner_req | (xfer & last_item));
  // On release the pointer becomes the old owner, so scan from there in the same cycle.
  assign pick_ptr    = busy ? owner_q : ptr_q;

  rr_pick #(
    .N (NUM_REQUESTERS)
  ) u_pick (
    .req_i   (in_request),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StBusy;
          owner_d = pick_idx;
          count_d = '0;
        end
      end
      StBusy: begin
        if (release_own) begin
          ptr_d   = owner_q;
          count_d = '0;
          if (pick_valid) begin
            owner_d = pick_idx;
          end else begin
            state_d = StIdle;
          end
        end else if (xfer) begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= OwnerW'(NUM_REQUESTERS - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    out_grant = '0;
    if (busy) begin
      out_grant[owner_q] = 1'b1;
    end
  end

  assign out_busy  = busy;
  assign out_owner = owner_q;
  assign out_put   = xfer;
  assign out_data  = xfer ? lanes[owner_q] : '0;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and constrained-random checks of the round-robin fifo write arbiter.
module tb_fifo_write_arbiter;

  logic        in_clock = 1'b0;
  logic        in_reset;
  logic [3:0]  in_request;
  logic [31:0] in_data;
  logic [3:0]  out_grant;
  logic [1:0]  out_owner;
  logic        out_busy;
  logic        in_full;
  logic        out_put;
  logic [7:0]  out_data;

  int errors = 0;
  int checks = 0;

  fifo_write_arbiter #(
    .NUM_REQUESTERS (4),
    .DATA_WIDTH     (8),
    .MAX_BURST      (4)
  ) dut (
    .in_clock   (in_clock),
    .in_reset   (in_reset),
    .in_request (in_request),
    .in_data    (in_data),
    .out_grant  (out_grant),
    .out_owner  (out_owner),
    .out_busy   (out_busy),
    .in_full    (in_full),
    .out_put    (out_put),
    .out_data   (out_data)
  );

  always #5 in_clock = ~in_clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge in_clock);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] v);
    in_data[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    in_reset   = 1'b1;
    in_request = '0;
    in_full    = 1'b0;
    next_cycle();
    next_cycle();
    in_reset = 1'b0;
  endtask

  logic [0:6] full_tbl = 7'b0011100;
  logic [0:6] put_tbl  = 7'b1100011;
  logic [7:0] item;
  logic       acc;

  logic       req_m  [4];
  logic [5:0] seq    [4];
  int         wait_n [4];

  initial begin
    in_reset   = 1'b1;
    in_request = '0;
    in_data    = '0;
    in_full    = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    check_eq("rst_put", {31'd0, out_put}, 32'd0);
    in_reset = 1'b0;
    #1;
    check_eq("rst_busy", {31'd0, out_busy}, 32'd0);
    check_eq("rst_grant", {28'd0, out_grant}, 32'd0);
    check_eq("rst_owner", {30'd0, out_owner}, 32'd0);

    // Sole requester 0: continuous puts across burst boundaries.
    in_request = 4'b0001;
    set_lane(0, 8'h11);
    #1;
    check_eq("t1_arb_put", {31'd0, out_put}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      #1;
      check_eq("t1_grant", {28'd0, out_grant}, 32'h1);
      check_eq("t1_put", {31'd0, out_put}, 32'd1);
      check_eq("t1_data", {24'd0, out_data}, 32'h11);
    end
    next_cycle();
    in_request = '0;
    #1;
    check_eq("t1_drop_put", {31'd0, out_put}, 32'd0);
    next_cycle();
    #1;
    check_eq("t1_idle", {31'd0, out_busy}, 32'd0);

    // All four requesting: bursts of 4 in order 0,1,2,3,0 with no handoff bubble.
    do_reset();
    in_request = 4'b1111;
    for (int i = 0; i < 4; i++) set_lane(i, 8'hA0 + 8'(i));
    #1;
    check_eq("t2_arb_busy", {31'd0, out_busy}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      #1;
      check_eq("t2_grant", {28'd0, out_grant}, 32'(1 << ((k / 4) % 4)));
      check_eq("t2_put", {31'd0, out_put}, 32'd1);
      check_eq("t2_data", {24'd0, out_data}, 32'hA0 + 32'((k / 4) % 4));
    end

    // Owner 1 stalled by full mid-burst; 4 distinct items then rotation to 2.
    do_reset();
    in_request = 4'b0110;
    item = 8'h31;
    set_lane(1, item);
    set_lane(2, 8'h40);
    acc = 1'b0;
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      if (acc) begin
        item = item + 8'd1;
        set_lane(1, item);
      end
      in_full = full_tbl[k];
      #1;
      check_eq("t3_put", {31'd0, out_put}, {31'd0, put_tbl[k]});
      check_eq("t3_data", {24'd0, out_data}, put_tbl[k] ? {24'd0, item} : 32'd0);
      check_eq("t3_owner", {30'd0, out_owner}, 32'd1);
      acc = put_tbl[k];
    end
    next_cycle();
    in_full = 1'b0;
    #1;
    check_eq("t3_items", {24'd0, item}, 32'h34);
    check_eq("t3_rot_grant", {28'd0, out_grant}, 32'h4);
    check_eq("t3_rot_data", {24'd0, out_data}, 32'h40);

    // Owner 2 drops after 2 items with 3 waiting: grant moves to 3.
    do_reset();
    in_request = 4'b1100;
    set_lane(2, 8'h52);
    set_lane(3, 8'h63);
    next_cycle();
    #1;
    check_eq("t4_grant2", {28'd0, out_grant}, 32'h4);
    check_eq("t4_data2", {24'd0, out_data}, 32'h52);
    next_cycle();
    #1;
    check_eq("t4_put2b", {31'd0, out_put}, 32'd1);
    next_cycle();
    in_request = 4'b1000;
    #1;
    check_eq("t4_drop_put", {31'd0, out_put}, 32'd0);
    next_cycle();
    #1;
    check_eq("t4_grant3", {28'd0, out_grant}, 32'h8);
    check_eq("t4_data3", {24'd0, out_data}, 32'h63);

    // Pointer left at 2: a 0-and-2 request picks 0 first.
    do_reset();
    in_request = 4'b0100;
    set_lane(0, 8'h0A);
    next_cycle();
    next_cycle();
    next_cycle();
    in_request = 4'b0000;
    #1;
    check_eq("t4b_drop_put", {31'd0, out_put}, 32'd0);
    next_cycle();
    in_request = 4'b0101;
    #1;
    check_eq("t4b_idle", {31'd0, out_busy}, 32'd0);
    next_cycle();
    #1;
    check_eq("t4b_grant0", {28'd0, out_grant}, 32'h1);
    check_eq("t4b_data0", {24'd0, out_data}, 32'h0A);

    // Reset mid-burst: no put in the reset cycle, requester 0 beats 3 afterwards.
    do_reset();
    in_request = 4'b0001;
    set_lane(0, 8'h11);
    set_lane(3, 8'h77);
    next_cycle();
    #1;
    check_eq("t5_put_pre", {31'd0, out_put}, 32'd1);
    next_cycle();
    in_reset   = 1'b1;
    in_request = 4'b1001;
    #1;
    check_eq("t5_rst_put", {31'd0, out_put}, 32'd0);
    next_cycle();
    in_reset = 1'b0;
    #1;
    check_eq("t5_busy", {31'd0, out_busy}, 32'd0);
    check_eq("t5_grant", {28'd0, out_grant}, 32'd0);
    next_cycle();
    #1;
    check_eq("t5_win0", {28'd0, out_grant}, 32'h1);
    check_eq("t5_data", {24'd0, out_data}, 32'h11);

    // Random requests and full: ordering, one-hot grant, no put when full, bounded wait.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_m[i]  = 1'b0;
      seq[i]    = '0;
      wait_n[i] = 0;
    end
    acc = 1'b0;
    item = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) next_cycle();
      if (acc) begin
        seq[item[1:0]]   = seq[item[1:0]] + 6'd1;
        req_m[item[1:0]] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 4; i++) begin
        if (!req_m[i] && $urandom_range(0, 1) == 1) begin
          req_m[i]  = 1'b1;
          wait_n[i] = 0;
        end
        in_request[i] = req_m[i];
        set_lane(i, {2'(i), seq[i]});
      end
      in_full = ($urandom_range(0, 3) == 0);
      #1;
      check_eq("rnd_onehot", {28'd0, out_grant & (out_grant - 4'd1)}, 32'd0);
      check_eq("rnd_full_put", {31'd0, out_put & in_full}, 32'd0);
      acc = out_put;
      if (out_put) begin
        item = {6'd0, out_owner};
        check_eq("rnd_grant", {28'd0, out_grant}, 32'(1 << out_owner));
        check_eq("rnd_order", {24'd0, out_data}, {24'd0, out_owner, seq[out_owner]});
        for (int i = 0; i < 4; i++) begin
          if (i == int'(out_owner)) begin
            wait_n[i] = 0;
          end else if (req_m[i]) begin
            wait_n[i]++;
            check_eq("rnd_starve", {31'd0, wait_n[i] > 16}, 32'd0);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
